triumph_wb_arbiter: RTL and testbench
=====================================

# triumph_wb_arbiter

Shares the single register-file write port between the EX-stage result and the LSU load-return path. EX results are buffered in a small in-order FIFO; LSU load data always wins, because the dcache cannot replay it. A starvation counter throttles new loads, and a busy query lets the ID stage stall on pending writes. Sits between EX/LSU and the `triumph_regfile_ff` write port.

## Interface
- `DEPTH`, 2: EX buffer entries; power of two, ≥2.
- `STARVE_MAX`, 4: consecutive LSU wins over a non-empty buffer before throttling; range 1..15.
- `clk_i` in 1: clock.
- `rstn_i` in 1: reset, asynchronous, active-high.
- `ex_valid_i` in 1: EX presents a result.
- `ex_ready_o` out 1: EX result accepted this cycle when high with `ex_valid_i`.
- `ex_rd_addr_i` in 5: EX destination register.
- `ex_rd_data_i` in 32: EX result.
- `lsu_valid_i` in 1: load data returning this cycle; never stalled.
- `lsu_rd_addr_i` in 5: load destination.
- `lsu_rd_data_i` in 32: load data.
- `lsu_hold_o` out 1: LSU must not issue new loads.
- `wb_valid_o` out 1: regfile write enable.
- `wb_addr_o` out 5: write address.
- `wb_data_o` out 32: write data.
- `wb_src_o` out 1: 1 = LSU source, 0 = EX source (debug/trace).
- `rs1_addr_i`, `rs2_addr_i` in 5 each: ID source registers.
- `rs_busy_o` out 1: a pending write targets rs1 or rs2.
- `pend_cnt_o` out $clog2(DEPTH)+1: buffer occupancy.

## Operation
- Per-cycle selection, in priority order:
  1. If `lsu_valid_i`, select the LSU.
  2. Else if the buffer is non-empty, select the buffer head and pop it.
  3. Else if `ex_valid_i && ex_ready_o`, bypass EX straight to the output.
  4. Else select nothing.
- The selected write is registered into `wb_*`. `wb_valid_o` is low when nothing is selected or the selected rd = 0.
- EX acceptance:
  - `ex_ready_o = (count < DEPTH)`, driven from registered state only. There is no combinational path from `lsu_valid_i`.
  - An accepted EX result is pushed unless it is bypassed (case 3).
  - An accepted result with rd = 0 is discarded: no push, no write.
- Simultaneous push and pop in one cycle: count unchanged.
- EX results retire strictly in order. LSU writes may overtake buffered EX writes. Ordering is the pipeline's responsibility; `rs_busy_o` exists so ID can stall.
- Starvation counter `starve_cnt`, 4 bits:
  - Increments when the LSU is selected while the buffer is non-empty.
  - Clears on any buffer pop or when the buffer is empty.
  - Saturates at `STARVE_MAX`.
  - `lsu_hold_o` is registered: it is high in the cycle after `starve_cnt` reaches `STARVE_MAX` and drops in the cycle after the next pop.
  - An LSU return arriving while `lsu_hold_o` is high (load already in flight) still takes priority.
- `rs_busy_o` is combinational. It is high if any valid buffer entry, the `wb_*` register (when `wb_valid_o`), or the current `lsu_valid_i` has a nonzero rd equal to `rs1_addr_i` or `rs2_addr_i`. Address 0 never asserts it.

## Timing
- Latency is one cycle from selection to `wb_valid_o`:
  - LSU return at cycle N: written at N+1.
  - EX bypass at cycle N: written at N+1.
  - A buffered EX result is written one cycle after it is popped.
- While `rstn_i` is high, asynchronously:
  - `wb_valid_o` = 0, `wb_addr_o` = 0, `wb_data_o` = 0, `wb_src_o` = 0.
  - `lsu_hold_o` = 0, `ex_ready_o` = 0, `pend_cnt_o` = 0.
  - Buffer is emptied and `starve_cnt` = 0.
- `ex_ready_o` rises in the first cycle after reset deasserts.
- Reset asserted mid-operation discards all buffered and registered writes. No partial write occurs.
- Full buffer: `ex_ready_o` = 0. EX must hold `ex_valid_i`, `ex_rd_addr_i` and `ex_rd_data_i` stable until accepted.
- Buffer pointers wrap modulo `DEPTH`.

## Test plan
- **Bypass:** empty buffer; EX presents rd=5, data=0x1234 at N → `wb_valid_o`=1, `wb_addr_o`=5, `wb_data_o`=0x1234, `wb_src_o`=0 at N+1; `pend_cnt_o` stays 0.
- **LSU priority:** same cycle, EX (rd=3, 0xA) and LSU (rd=4, 0xB):
  - Required: LSU write (4, 0xB) at N+1; EX (3, 0xA) buffered, `pend_cnt_o`=1; EX write at N+2.
- **Fill and backpressure:** hold `lsu_valid_i`=1 while EX sends 3 results:
  - Required: first two accepted; `ex_ready_o`=0 at `pend_cnt_o`=2; third accepted one cycle after LSU goes idle.
  - Required: writes retire in EX order after the LSU traffic.
- **Starvation:** buffer holds 1 entry, `lsu_valid_i` held high for 6 cycles, `STARVE_MAX`=4:
  - Required: `lsu_hold_o` rises after the 4th win.
  - Required: when the LSU releases, the entry pops and `lsu_hold_o` falls one cycle later.
- **x0 and busy:** EX rd=0 → accepted, no write, no push.
  - With rd=7 buffered and `rs1_addr_i`=7 → `rs_busy_o`=1.
  - With `rs2_addr_i`=0 and `rs1_addr_i`≠7 → `rs_busy_o`=0.
- **Reset mid-operation:** 2 entries buffered, `wb_valid_o`=1; assert `rstn_i` between clock edges:
  - Required: immediately all outputs 0 and `pend_cnt_o`=0.
  - Required: no write after release; `ex_ready_o`=1 on the first cycle after release.

Source files
------------

// File: rtl/triumph_wb_arbiter.sv
// triumph_wb_arbiter
// Shares the single register-file write port between EX results and LSU
// load returns. LSU data always wins because the dcache cannot replay it.
// EX results wait in a small in-order buffer. A starvation counter raises
// lsu_hold_o so the buffer can drain. rs_busy_o lets ID stall on writes
// that are still pending.
//
// Ports
//   clk_i, rstn_i                  clock; asynchronous reset, active-high
//   ex_valid_i/ex_ready_o          EX result handshake
//   ex_rd_addr_i/ex_rd_data_i      EX destination and result
//   lsu_valid_i                    load return this cycle (never stalled)
//   lsu_rd_addr_i/lsu_rd_data_i    load destination and data
//   lsu_hold_o                     LSU must not issue new loads
//   wb_valid_o/wb_addr_o/wb_data_o registered regfile write port
//   wb_src_o                       1 = LSU wrote, 0 = EX wrote (trace)
//   rs1_addr_i/rs2_addr_i          ID source registers
//   rs_busy_o                      a pending write targets rs1 or rs2
//   pend_cnt_o                     EX buffer occupancy
//
// Handshake: an EX result transfers on a rising clock edge where
// ex_valid_i and ex_ready_o are both high. ex_ready_o comes from registered
// state only. Until the result transfers, EX holds ex_valid_i,
// ex_rd_addr_i and ex_rd_data_i stable.
module triumph_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   ex_valid_i,
  output logic                   ex_ready_o,
  input  logic [4:0]             ex_rd_addr_i,
  input  logic [31:0]            ex_rd_data_i,
  input  logic                   lsu_valid_i,
  input  logic [4:0]             lsu_rd_addr_i,
  input  logic [31:0]            lsu_rd_data_i,
  output logic                   lsu_hold_o,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_addr_o,
  output logic [31:0]            wb_data_o,
  output logic                   wb_src_o,
  input  logic [4:0]             rs1_addr_i,
  input  logic [4:0]             rs2_addr_i,
  output logic                   rs_busy_o,
  output logic [$clog2(DEPTH):0] pend_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       r_mem_addr [DEPTH];
  logic [31:0]      r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_slot_vld;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_starve;
  logic             r_hold;
  logic             r_run;
  logic             r_wb_valid;
  logic [4:0]       r_wb_addr;
  logic [31:0]      r_wb_data;
  logic             r_wb_src;

  logic             w_empty;
  logic             w_ex_ready;
  logic             w_ex_acc;
  logic             w_pop;
  logic             w_byp;
  logic             w_push;
  logic [3:0]       w_starve_next;
  logic             w_sel_valid;
  logic             w_sel_src;
  logic [4:0]       w_sel_addr;
  logic [31:0]      w_sel_data;
  logic             w_busy;

  // r_run keeps ex_ready_o low until the first clock edge after reset.
  assign w_empty    = (r_count == '0);
  assign w_ex_ready = r_run && (r_count < CW'(DEPTH));
  assign w_ex_acc   = ex_valid_i && w_ex_ready;

  // Priority: LSU, then buffer head, then EX bypass when the buffer is empty.
  assign w_pop  = !lsu_valid_i && !w_empty;
  assign w_byp  = !lsu_valid_i && w_empty && w_ex_acc;
  // An accepted write to x0 is dropped here. It never occupies a slot.
  assign w_push = w_ex_acc && (ex_rd_addr_i != 5'd0) && !w_byp;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_src   = 1'b0;
    w_sel_addr  = 5'd0;
    w_sel_data  = 32'd0;
    if (lsu_valid_i) begin
      w_sel_valid = 1'b1;
      w_sel_src   = 1'b1;
      w_sel_addr  = lsu_rd_addr_i;
      w_sel_data  = lsu_rd_data_i;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = r_mem_addr[r_rd_ptr];
      w_sel_data  = r_mem_data[r_rd_ptr];
    end else if (w_ex_acc) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = ex_rd_addr_i;
      w_sel_data  = ex_rd_data_i;
    end
  end

  // The count only rises while the LSU keeps winning over buffered work.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || w_empty) begin
      w_starve_next = 4'd0;
    end else if (lsu_valid_i && (r_starve < 4'(STARVE_MAX))) begin
      w_starve_next = r_starve + 4'd1;
    end
  end

  // Hazard check covers buffered entries, the write in flight and today's load.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_slot_vld[i] && (r_mem_addr[i] != 5'd0) &&
          ((r_mem_addr[i] == rs1_addr_i) || (r_mem_addr[i] == rs2_addr_i))) begin
        w_busy = 1'b1;
      end
    end
    if (r_wb_valid && (r_wb_addr != 5'd0) &&
        ((r_wb_addr == rs1_addr_i) || (r_wb_addr == rs2_addr_i))) begin
      w_busy = 1'b1;
    end
    if (lsu_valid_i && (lsu_rd_addr_i != 5'd0) &&
        ((lsu_rd_addr_i == rs1_addr_i) || (lsu_rd_addr_i == rs2_addr_i))) begin
      w_busy = 1'b1;
    end
  end

  // Payload storage needs no reset. Slot validity and count decide the meaning.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= ex_rd_addr_i;
      r_mem_data[r_wr_ptr] <= ex_rd_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      r_slot_vld <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= 4'd0;
      r_hold     <= 1'b0;
      r_run      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= 5'd0;
      r_wb_data  <= 32'd0;
      r_wb_src   <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_wb_valid <= w_sel_valid && (w_sel_addr != 5'd0);
      r_wb_addr  <= w_sel_addr;
      r_wb_data  <= w_sel_data;
      r_wb_src   <= w_sel_src;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_slot_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_slot_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_starve <= w_starve_next;
      r_hold   <= (w_starve_next == 4'(STARVE_MAX));
    end
  end

  assign ex_ready_o = w_ex_ready;
  assign lsu_hold_o = r_hold;
  assign wb_valid_o = r_wb_valid;
  assign wb_addr_o  = r_wb_addr;
  assign wb_data_o  = r_wb_data;
  assign wb_src_o   = r_wb_src;
  assign rs_busy_o  = w_busy;
  assign pend_cnt_o = r_count;

endmodule

// File: tb/tb_triumph_wb_arbiter.sv
module tb_triumph_wb_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic        clk_i  = 1'b0;
  logic        rstn_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic [4:0]  ex_rd_addr_i = 5'd0;
  logic [31:0] ex_rd_data_i = 32'd0;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_rd_addr_i = 5'd0;
  logic [31:0] lsu_rd_data_i = 32'd0;
  logic [4:0]  rs1_addr_i = 5'd0;
  logic [4:0]  rs2_addr_i = 5'd0;
  logic        ex_ready_o;
  logic        lsu_hold_o;
  logic        wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_src_o;
  logic        rs_busy_o;
  logic [$clog2(DEPTH):0] pend_cnt_o;

  always #5 clk_i = ~clk_i;

  triumph_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_addr_i(lsu_rd_addr_i),
    .lsu_rd_data_i(lsu_rd_data_i), .lsu_hold_o(lsu_hold_o),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_src_o(wb_src_o), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs_busy_o(rs_busy_o), .pend_cnt_o(pend_cnt_o)
  );

  int checks   = 0;
  int failures = 0;
  logic tb_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending EX writes in program order, {addr, data}.
  logic [36:0] exp_q[$];
  logic        m_run = 1'b0;
  logic        m_wb_valid = 1'b0;
  logic [4:0]  m_wb_addr = 5'd0;
  logic [31:0] m_wb_data = 32'd0;
  logic        m_wb_src = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_last_acc = 1'b0;
  int          m_starve = 0;

  task automatic m_reset();
    exp_q.delete();
    m_run = 1'b0; m_wb_valid = 1'b0; m_wb_addr = 5'd0; m_wb_data = 32'd0;
    m_wb_src = 1'b0; m_hold = 1'b0; m_last_acc = 1'b0; m_starve = 0;
  endtask

  task automatic m_step();
    logic acc, byp, popped, was_empty;
    logic [36:0] head;
    was_empty = (exp_q.size() == 0);
    acc    = ex_valid_i && m_run && (exp_q.size() < DEPTH);
    byp    = 1'b0;
    popped = 1'b0;
    if (lsu_valid_i) begin
      m_wb_valid = (lsu_rd_addr_i != 5'd0);
      m_wb_addr = lsu_rd_addr_i; m_wb_data = lsu_rd_data_i; m_wb_src = 1'b1;
    end else if (!was_empty) begin
      head = exp_q.pop_front();
      m_wb_valid = 1'b1; m_wb_addr = head[36:32]; m_wb_data = head[31:0]; m_wb_src = 1'b0;
      popped = 1'b1;
    end else if (acc) begin
      byp = 1'b1;
      m_wb_valid = (ex_rd_addr_i != 5'd0);
      m_wb_addr = ex_rd_addr_i; m_wb_data = ex_rd_data_i; m_wb_src = 1'b0;
    end else begin
      m_wb_valid = 1'b0;
    end
    if (acc && !byp && ex_rd_addr_i != 5'd0) exp_q.push_back({ex_rd_addr_i, ex_rd_data_i});
    if (popped || was_empty) m_starve = 0;
    else if (lsu_valid_i) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
    m_hold     = (m_starve == STARVE_MAX);
    m_last_acc = acc;
    m_run      = 1'b1;
  endtask

  function automatic logic hit(input logic [4:0] a);
    return (a != 5'd0) && ((a == rs1_addr_i) || (a == rs2_addr_i));
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    foreach (exp_q[i]) if (hit(exp_q[i][36:32])) b = 1'b1;
    if (m_wb_valid && hit(m_wb_addr)) b = 1'b1;
    if (lsu_valid_i && hit(lsu_rd_addr_i)) b = 1'b1;
    return b;
  endfunction

  always @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) m_reset();
    else        m_step();
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_i) begin
    if (!tb_done) begin
      chk("wb_valid", 32'(wb_valid_o), 32'(m_wb_valid));
      if (m_wb_valid) begin
        chk("wb_addr", 32'(wb_addr_o), 32'(m_wb_addr));
        chk("wb_data", wb_data_o, m_wb_data);
        chk("wb_src", 32'(wb_src_o), 32'(m_wb_src));
      end
      chk("pend_cnt", 32'(pend_cnt_o), 32'(exp_q.size()));
      chk("ex_ready", 32'(ex_ready_o), 32'(m_run && (exp_q.size() < DEPTH)));
      chk("lsu_hold", 32'(lsu_hold_o), 32'(m_hold));
      chk("rs_busy", 32'(rs_busy_o), 32'(m_busy()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_in(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    ex_valid_i = ev; ex_rd_addr_i = ea; ex_rd_data_i = ed;
    lsu_valid_i = lv; lsu_rd_addr_i = la; lsu_rd_data_i = ld;
  endtask

  initial begin
    int prob;
    m_reset();
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_pend", 32'(pend_cnt_o), 32'd0);
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd0);
    chk("rst_hold", 32'(lsu_hold_o), 32'd0);
    rstn_i = 1'b0;
    tick();
    chk("ready_after_rst", 32'(ex_ready_o), 32'd1);

    // Bypass
    set_in(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    tick();
    set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("byp_valid", 32'(wb_valid_o), 32'd1);
    chk("byp_addr", 32'(wb_addr_o), 32'd5);
    chk("byp_data", wb_data_o, 32'h1234);
    chk("byp_src", 32'(wb_src_o), 32'd0);
    chk("byp_pend", 32'(pend_cnt_o), 32'd0);

    // LSU priority
    set_in(1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    tick();
    set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    chk("pri_lsu_addr", 32'(wb_addr_o), 32'd4);
    chk("pri_lsu_data", wb_data_o, 32'hB);
    chk("pri_lsu_src", 32'(wb_src_o), 32'd1);
    chk("pri_pend", 32'(pend_cnt_o), 32'd1);
    tick();
    chk("pri_ex_addr", 32'(wb_addr_o), 32'd3);
    chk("pri_ex_data", wb_data_o, 32'hA);
    chk("pri_ex_src", 32'(wb_src_o), 32'd0);

    // Fill and backpressure
    set_in(1, 5'd11, 32'h111, 1, 5'd20, 32'h200);
    tick();
    set_in(1, 5'd12, 32'h222, 1, 5'd20, 32'h201);
    tick();
    chk("fill_pend2", 32'(pend_cnt_o), 32'd2);
    chk("fill_not_ready", 32'(ex_ready_o), 32'd0);
    set_in(1, 5'd13, 32'h333, 1, 5'd21, 32'h202);
    tick();
    chk("fill_still_full", 32'(pend_cnt_o), 32'd2);
    tick();
    lsu_valid_i = 1'b0;
    tick();
    chk("fill_wb1", 32'(wb_addr_o), 32'd11);
    chk("fill_ready_again", 32'(ex_ready_o), 32'd1);
    tick();
    ex_valid_i = 1'b0;
    chk("fill_wb2", 32'(wb_addr_o), 32'd12);
    chk("fill_pend_third", 32'(pend_cnt_o), 32'd1);
    tick();
    chk("fill_wb3", 32'(wb_addr_o), 32'd13);
    chk("fill_wb3_data", wb_data_o, 32'h333);
    chk("fill_pend0", 32'(pend_cnt_o), 32'd0);

    // Starvation
    set_in(1, 5'd9, 32'h99, 1, 5'd1, 32'h11);
    tick();
    set_in(0, 5'd0, 32'd0, 1, 5'd1, 32'h11);
    repeat (3) tick();
    chk("starve_hold_3", 32'(lsu_hold_o), 32'd0);
    tick();
    chk("starve_hold_4", 32'(lsu_hold_o), 32'd1);
    repeat (2) tick();
    chk("starve_hold_6", 32'(lsu_hold_o), 32'd1);
    chk("starve_pend", 32'(pend_cnt_o), 32'd1);
    set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    tick();
    chk("starve_hold_drop", 32'(lsu_hold_o), 32'd0);
    chk("starve_pop_addr", 32'(wb_addr_o), 32'd9);
    chk("starve_pop_valid", 32'(wb_valid_o), 32'd1);

    // x0 and busy
    set_in(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0);
    tick();
    chk("x0_no_write", 32'(wb_valid_o), 32'd0);
    chk("x0_no_push", 32'(pend_cnt_o), 32'd0);
    set_in(1, 5'd7, 32'h77, 1, 5'd2, 32'h22);
    tick();
    set_in(0, 5'd0, 32'd0, 1, 5'd2, 32'h22);
    rs1_addr_i = 5'd7; rs2_addr_i = 5'd0;
    #1;
    chk("busy_rs1", 32'(rs_busy_o), 32'd1);
    rs1_addr_i = 5'd3;
    #1;
    chk("busy_clear", 32'(rs_busy_o), 32'd0);
    set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    rs1_addr_i = 5'd0;
    repeat (2) tick();

    // Reset mid-operation
    set_in(1, 5'd14, 32'hE, 1, 5'd5, 32'h55);
    tick();
    set_in(1, 5'd15, 32'hF, 1, 5'd5, 32'h56);
    tick();
    chk("mid_pend2", 32'(pend_cnt_o), 32'd2);
    chk("mid_wb_valid", 32'(wb_valid_o), 32'd1);
    #1;
    rstn_i = 1'b1;
    set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    #1;
    chk("mid_rst_valid", 32'(wb_valid_o), 32'd0);
    chk("mid_rst_addr", 32'(wb_addr_o), 32'd0);
    chk("mid_rst_data", wb_data_o, 32'd0);
    chk("mid_rst_src", 32'(wb_src_o), 32'd0);
    chk("mid_rst_hold", 32'(lsu_hold_o), 32'd0);
    chk("mid_rst_ready", 32'(ex_ready_o), 32'd0);
    chk("mid_rst_pend", 32'(pend_cnt_o), 32'd0);
    tick();
    rstn_i = 1'b0;
    tick();
    chk("post_rst_no_write", 32'(wb_valid_o), 32'd0);
    chk("post_rst_ready", 32'(ex_ready_o), 32'd1);
    tick();
    chk("post_rst_no_write2", 32'(wb_valid_o), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c == 2500) begin
        rstn_i = 1'b1;
        tick();
        rstn_i = 1'b0;
      end
      if (!(ex_valid_i && !m_last_acc)) begin
        ex_valid_i   = ($urandom_range(0, 99) < 55);
        ex_rd_addr_i = 5'($urandom_range(0, 7));
        ex_rd_data_i = $urandom();
      end
      prob = (c < 2000) ? 35 : 70;
      if (m_hold) prob = 10;
      lsu_valid_i   = ($urandom_range(0, 99) < prob);
      lsu_rd_addr_i = 5'($urandom_range(0, 7));
      lsu_rd_data_i = $urandom();
      rs1_addr_i    = 5'($urandom_range(0, 7));
      rs2_addr_i    = 5'($urandom_range(0, 7));
    end

    tick();
    tb_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
